// File: rtl/arb_mux_reg.sv
// NUM_CH:1 channel multiplexer with manual or round-robin grant feeding a one-deep output register.
// Define ARB_MUX_STATS_EN to add the xfer_cnt output-handshake counter and its cnt_clr input.
module arb_mux_reg #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 32,
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch
`ifdef ARB_MUX_STATS_EN
  ,
  input  logic                     cnt_clr,
  output logic [31:0]              xfer_cnt
`endif
);

  // Handshakes: a transfer on channel k happens when in_valid[k] && in_ready[k];
  // the output word leaves when out_valid && out_ready. in_ready never depends on in_ready.
  logic              load_ok;
  logic              gnt_vld;
  logic              rr_vld;
  logic              xfer;
  logic [SEL_W-1:0]  gnt;
  logic [SEL_W-1:0]  rr_gnt;
  logic [SEL_W-1:0]  rr_ptr;
  logic [DATA_W-1:0] gnt_data;

  assign load_ok = !out_valid || out_ready;

  // Walk from the highest offset down so the closest valid channel after rr_ptr wins.
  always_comb begin
    int idx;
    idx    = 0;
    rr_vld = 1'b0;
    rr_gnt = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % NUM_CH;
      if (in_valid[idx]) begin
        rr_vld = 1'b1;
        rr_gnt = SEL_W'(idx);
      end
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    if (mode) begin
      gnt_vld = rr_vld;
      gnt     = rr_gnt;
    end else if (int'(sel) < NUM_CH) begin
      gnt_vld = 1'b1;
      gnt     = sel;
    end
  end

  always_comb begin
    in_ready = '0;
    if (rst_n && gnt_vld) in_ready[gnt] = load_ok;
  end

  assign xfer     = rst_n && gnt_vld && in_valid[gnt] && load_ok;
  assign gnt_data = in_data[int'(gnt)*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_ch    <= gnt;
      if (mode) rr_ptr <= (int'(gnt) == NUM_CH - 1) ? '0 : gnt + SEL_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ARB_MUX_STATS_EN
  // Clear wins over a same-cycle handshake.
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) xfer_cnt <= '0;
    else if (out_valid && out_ready) xfer_cnt <= xfer_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_arb_mux_reg.sv
// Bench for arb_mux_reg: an 8-channel and a 5-channel instance share stimulus and are
// compared with a queue-based reference model, plus vector tables and corner sequences.
module tb_arb_mux_reg;

  logic         clk;
  logic         rst_n;
  logic         mode;
  logic [2:0]   sel;
  logic [7:0]   in_valid;
  logic [7:0]   in_ready;
  logic [255:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic [2:0]   out_ch;
  logic [4:0]   in_ready5;
  logic         out_valid5;
  logic [31:0]  out_data5;
  logic [2:0]   out_ch5;
`ifdef ARB_MUX_STATS_EN
  logic         cnt_clr;
  logic [31:0]  xfer_cnt;
  logic [31:0]  xfer_cnt5;
`endif

  logic [31:0] dw [8];
  int errors = 0;
  int checks = 0;

  arb_mux_reg #(.NUM_CH(8), .DATA_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch)
`ifdef ARB_MUX_STATS_EN
    , .cnt_clr(cnt_clr), .xfer_cnt(xfer_cnt)
`endif
  );

  arb_mux_reg #(.NUM_CH(5), .DATA_W(32)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid[4:0]), .in_ready(in_ready5), .in_data(in_data[159:0]),
    .out_valid(out_valid5), .out_ready(out_ready), .out_data(out_data5), .out_ch(out_ch5)
`ifdef ARB_MUX_STATS_EN
    , .cnt_clr(cnt_clr), .xfer_cnt(xfer_cnt5)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    in_data = '0;
    for (int k = 0; k < 8; k++) in_data[k*32 +: 32] = dw[k];
  end

  // Reference model: output register contents plus round-robin pointer
  typedef struct {
    bit          v;
    logic [31:0] d;
    int          ch;
    int          ptr;
  } mstate_t;

  mstate_t m8, m5;

  function automatic int mgrant(input mstate_t s, input int n);
    int order[$];
    if (!mode) return (int'(sel) < n) ? int'(sel) : -1;
    for (int k = 0; k < n; k++) order.push_back((s.ptr + k) % n);
    foreach (order[j]) if (in_valid[order[j]]) return order[j];
    return -1;
  endfunction

  function automatic logic [7:0] mready(input mstate_t s, input int n);
    int g;
    g = mgrant(s, n);
    if (!rst_n || g < 0) return 8'h00;
    return (!s.v || out_ready) ? 8'(1 << g) : 8'h00;
  endfunction

  function automatic mstate_t mnext(input mstate_t s, input int n);
    mstate_t r;
    int g;
    r = s;
    if (!rst_n) begin
      r = '{1'b0, 32'd0, 0, 0};
      return r;
    end
    g = mgrant(s, n);
    if (g >= 0 && (!s.v || out_ready) && in_valid[g]) begin
      r.v  = 1'b1;
      r.d  = dw[g];
      r.ch = g;
      if (mode) r.ptr = (g + 1) % n;
    end else if (s.v && out_ready) begin
      r.v = 1'b0;
    end
    return r;
  endfunction

  // Scoreboard
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: check ready before the edge, advance the model, check outputs at negedge.
  task automatic cyc();
    logic [7:0] er8, er5;
    #1;
    er8 = mready(m8, 8);
    er5 = mready(m5, 5);
    chk("in_ready8", 32'(in_ready), 32'(er8));
    chk("in_ready5", 32'(in_ready5), 32'(er5));
    @(posedge clk);
    m8 = mnext(m8, 8);
    m5 = mnext(m5, 5);
    @(negedge clk);
    chk("out_valid8", 32'(out_valid), 32'(m8.v));
    chk("out_data8", out_data, m8.d);
    chk("out_ch8", 32'(out_ch), 32'(m8.ch));
    chk("out_valid5", 32'(out_valid5), 32'(m5.v));
    chk("out_data5", out_data5, m5.d);
    chk("out_ch5", 32'(out_ch5), 32'(m5.ch));
  endtask

  // Driver
  task automatic set_in(input logic md, input logic [2:0] sl, input logic [7:0] vl, input logic ordy);
    mode      = md;
    sel       = sl;
    in_valid  = vl;
    out_ready = ordy;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       md;
    logic [2:0] sl;
    logic [7:0] vl;
    logic       ordy;
    logic [7:0] e_rdy;
    logic       e_ov;
    logic [2:0] e_ch;
  } vec_t;

  vec_t vt[$];

  initial begin
    // Vector table: manual sweep, round-robin over all 8, round-robin over channels 2 and 5
    for (int i = 0; i < 8; i++) vt.push_back('{1'b0, 3'(i), 8'hFF, 1'b1, 8'(1 << i), 1'b1, 3'(i)});
    for (int j = 0; j < 10; j++) vt.push_back('{1'b1, 3'd0, 8'hFF, 1'b1, 8'(1 << (j % 8)), 1'b1, 3'(j % 8)});
    for (int j = 0; j < 4; j++) begin
      if (j % 2 == 0) vt.push_back('{1'b1, 3'd0, 8'h24, 1'b1, 8'h04, 1'b1, 3'd2});
      else            vt.push_back('{1'b1, 3'd0, 8'h24, 1'b1, 8'h20, 1'b1, 3'd5});
    end

    m8 = '{1'b0, 32'd0, 0, 0};
    m5 = '{1'b0, 32'd0, 0, 0};
`ifdef ARB_MUX_STATS_EN
    cnt_clr = 1'b0;
`endif
    for (int k = 0; k < 8; k++) dw[k] = 32'h100 + k;

    // Reset held two cycles with every channel valid
    set_in(1'b0, 3'd0, 8'hFF, 1'b1);
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_ch", 32'(out_ch), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
    end
    rst_n = 1'b1;
    sel   = 3'd3;
    cyc();
    chk("first_word_valid", 32'(out_valid), 32'd1);
    chk("first_word_data", out_data, 32'h103);

    // Table-driven vectors with channel k carrying value k
    for (int k = 0; k < 8; k++) dw[k] = 32'(k);
    do_reset();
    for (int i = 0; i < vt.size(); i++) begin
      set_in(vt[i].md, vt[i].sl, vt[i].vl, vt[i].ordy);
      #1 chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(vt[i].e_rdy));
      cyc();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
      chk($sformatf("vec%0d_ch", i), 32'(out_ch), 32'(vt[i].e_ch));
      chk($sformatf("vec%0d_data", i), out_data, 32'(vt[i].e_ch));
    end

    // Backpressure: held word stays put, no ready, pointer frozen, then no bubble
    do_reset();
    dw[3] = 32'hDEADBEEF;
    set_in(1'b0, 3'd3, 8'hFF, 1'b1);
    cyc();
    chk("bp_load", out_data, 32'hDEADBEEF);
    set_in(1'b1, 3'd0, 8'hFF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_in_ready", 32'(in_ready), 32'd0);
      cyc();
      chk("bp_hold_data", out_data, 32'hDEADBEEF);
      chk("bp_hold_ch", 32'(out_ch), 32'd3);
    end
    out_ready = 1'b1;
    cyc();
    chk("bp_release_valid", 32'(out_valid), 32'd1);
    chk("bp_release_ch", 32'(out_ch), 32'd0);
    cyc();
    chk("bp_next_ch", 32'(out_ch), 32'd1);

    // Five-channel instance: select beyond the last channel grants nothing
    do_reset();
    set_in(1'b0, 3'd6, 8'hFF, 1'b1);
    #1 chk("sel6_ready5", 32'(in_ready5), 32'd0);
    cyc();
    chk("sel6_valid5", 32'(out_valid5), 32'd0);
    sel = 3'd4;
    cyc();
    chk("sel4_valid5", 32'(out_valid5), 32'd1);
    chk("sel4_ch5", 32'(out_ch5), 32'd4);

    // Reset while a word is held under backpressure
    set_in(1'b0, 3'd1, 8'hFF, 1'b1);
    cyc();
    out_ready = 1'b0;
    rst_n     = 1'b0;
    cyc();
    chk("rst_held_valid", 32'(out_valid), 32'd0);
    chk("rst_held_valid5", 32'(out_valid5), 32'd0);
    rst_n = 1'b1;

`ifdef ARB_MUX_STATS_EN
    do_reset();
    set_in(1'b1, 3'd0, 8'hFF, 1'b1);
    for (int i = 0; i < 11; i++) cyc();
    chk("xfer_cnt_10", xfer_cnt, 32'd10);
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    chk("xfer_cnt_clr", xfer_cnt, 32'd0);
`endif

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 40) != 0);
      for (int k = 0; k < 8; k++) dw[k] = $urandom;
      set_in(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
             ($urandom_range(0, 3) != 0));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
